// File: rtl/elbeth_pc_unit.sv
// Program counter unit: boot sequencing, branch/exception redirect with
// stall-safe pending capture, and optional target alignment checking.
//
// Parameters:
//   XLEN          PC and target width (16..64)
//   RESET_VECTOR  PC value loaded by reset
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   ctrl_stall     1 = hold the PC
//   branch_taken   branch/jump redirect request, target in branch_target
//   exc_req        exception/trap redirect request, target in exc_target
//   pc             registered current fetch address
//   pc_seq         combinational pc + 4 (wraps)
//   pc_valid       registered, 1 when pc is fetchable (RUN/HOLD)
//   misaligned     registered pulse on a misaligned applied redirect
// Build option:
//   ELBETH_PC_ALIGN_CHECK_EN  when defined, applied redirect targets get
//   bits [1:0] cleared and misaligned pulses; otherwise misaligned is 0.

module elbeth_pc_unit #(
  parameter int unsigned        XLEN         = 32,
  parameter logic [XLEN-1:0]    RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            exc_req,
  input  logic [XLEN-1:0] exc_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_seq,
  output logic            pc_valid,
  output logic            misaligned
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_EXC  = 2'd1;
  localparam logic [1:0] SRC_BR   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]      pend_src_q, pend_src_d;
  logic            pc_valid_q, pc_valid_d;
  logic            apply;
  logic [XLEN-1:0] redir;

  assign pc_seq = pc_q + XLEN'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_src_d = pend_src_q;
    apply      = 1'b0;
    redir      = pc_seq;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!ctrl_stall) begin
          if (exc_req) begin
            apply = 1'b1;
            redir = exc_target;
          end else if (branch_taken) begin
            apply = 1'b1;
            redir = branch_target;
          end else begin
            pc_d = pc_seq;
          end
        end else if (exc_req || branch_taken) begin
          pend_tgt_d = exc_req ? exc_target : branch_target;
          pend_src_d = exc_req ? SRC_EXC : SRC_BR;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ctrl_stall) begin
          if (exc_req) begin
            pend_tgt_d = exc_target;
            pend_src_d = SRC_EXC;
          end else if (branch_taken && pend_src_q == SRC_BR) begin
            pend_tgt_d = branch_target;
          end
        end else begin
          apply = 1'b1;
          if (exc_req)
            redir = exc_target;
          else if (branch_taken && pend_src_q == SRC_BR)
            redir = branch_target;
          else
            redir = pend_tgt_q;
          pend_src_d = SRC_NONE;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    if (apply) begin
`ifdef ELBETH_PC_ALIGN_CHECK_EN
      pc_d = {redir[XLEN-1:2], 2'b00};
`else
      pc_d = redir;
`endif
    end
    pc_valid_d = (state_d != ST_BOOT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      pend_tgt_q <= '0;
      pend_src_q <= SRC_NONE;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_src_q <= pend_src_d;
      pc_valid_q <= pc_valid_d;
    end
  end

`ifdef ELBETH_PC_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  // Pulse lines up with the cycle the corrected pc is presented.
  assign misaligned_d = apply && (redir[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      misaligned_q <= 1'b0;
    else
      misaligned_q <= misaligned_d;
  end

  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;

endmodule

// File: tb/tb_elbeth_pc_unit.sv
// Directed testbench for elbeth_pc_unit: boot, priority, stall capture,
// pending override rules, wrap, reset mid-HOLD, and target alignment.

module tb_elbeth_pc_unit;

  logic        clk;
  logic        rst;
  logic        ctrl_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exc_req;
  logic [31:0] exc_target;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic        pc_valid;
  logic        misaligned;

  int checks;
  int failures;

  elbeth_pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_stall(ctrl_stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .exc_req(exc_req),
    .exc_target(exc_target),
    .pc(pc),
    .pc_seq(pc_seq),
    .pc_valid(pc_valid),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ctrl_stall   = 1'b0;
    branch_taken = 1'b0;
    exc_req      = 1'b0;
  endtask

  task automatic jump(input logic [31:0] t);
    idle();
    branch_taken  = 1'b1;
    branch_target = t;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h0;
    exp_seq[1] = 32'h4;
    exp_seq[2] = 32'h8;
    idle();
    branch_target = '0;
    exc_target    = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_async pc=%h valid=%b mis=%b exp 0/0/0",
               pc, pc_valid, misaligned);
    end
    tick();
    tick();
    rst = 1'b1;
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL boot pc=%h valid=%b exp 0/0", pc, pc_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== exp_seq[i] || pc_valid !== 1'b1) begin
        failures++;
        $display("FAIL run_seq%0d pc=%h valid=%b exp %h/1",
                 i, pc, pc_valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_coincident();
    jump(32'h100);
    checks++;
    if (pc !== 32'h100) begin
      failures++;
      $display("FAIL branch_0x100 pc=%h exp 00000100", pc);
    end
    exc_req       = 1'b1;
    exc_target    = 32'h200;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    tick();
    idle();
    checks++;
    if (pc !== 32'h200) begin
      failures++;
      $display("FAIL coincident pc=%h exp 00000200", pc);
    end
    checks++;
    if (pc_seq !== 32'h204) begin
      failures++;
      $display("FAIL pc_seq pc_seq=%h exp 00000204", pc_seq);
    end
  endtask

  task automatic test_stalled_redirect();
    jump(32'h40);
    ctrl_stall    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (pc !== 32'h40 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_capture pc=%h valid=%b exp 00000040/1",
               pc, pc_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h40) begin
        failures++;
        $display("FAIL stall_hold%0d pc=%h exp 00000040", i, pc);
      end
    end
    ctrl_stall = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h80) begin
      failures++;
      $display("FAIL stall_release pc=%h exp 00000080", pc);
    end
    tick();
    checks++;
    if (pc !== 32'h84) begin
      failures++;
      $display("FAIL after_release pc=%h exp 00000084", pc);
    end
  endtask

  task automatic test_exc_over_branch();
    ctrl_stall    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    exc_req      = 1'b1;
    exc_target   = 32'h1C0;
    tick();
    exc_req       = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    tick();
    checks++;
    if (pc !== 32'h84) begin
      failures++;
      $display("FAIL exc_hold pc=%h exp 00000084", pc);
    end
    ctrl_stall = 1'b0;
    tick();
    idle();
    checks++;
    if (pc !== 32'h1C0) begin
      failures++;
      $display("FAIL exc_over_branch pc=%h exp 000001c0", pc);
    end
    tick();
    checks++;
    if (pc !== 32'h1C4) begin
      failures++;
      $display("FAIL exc_then_seq pc=%h exp 000001c4", pc);
    end
  endtask

  task automatic test_branch_overwrite();
    ctrl_stall    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    tick();
    branch_target = 32'h90;
    tick();
    idle();
    tick();
    checks++;
    if (pc !== 32'h90) begin
      failures++;
      $display("FAIL branch_overwrite pc=%h exp 00000090", pc);
    end
  endtask

  task automatic test_wrap();
    jump(32'hFFFF_FFFC);
    checks++;
    if (pc_seq !== 32'h0) begin
      failures++;
      $display("FAIL wrap_seq pc_seq=%h exp 00000000", pc_seq);
    end
    tick();
    checks++;
    if (pc !== 32'h0) begin
      failures++;
      $display("FAIL wrap pc=%h exp 00000000", pc);
    end
  endtask

  task automatic test_reset_mid_hold();
    jump(32'h600);
    ctrl_stall    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h500;
    tick();
    idle();
    ctrl_stall = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold pc=%h valid=%b exp 0/0", pc, pc_valid);
    end
    tick();
    rst           = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h700;
    tick();
    idle();
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL boot_ignores_req pc=%h valid=%b exp 0/1",
               pc, pc_valid);
    end
    tick();
    checks++;
    if (pc !== 32'h4) begin
      failures++;
      $display("FAIL pending_discarded pc=%h exp 00000004", pc);
    end
  endtask

  task automatic test_align();
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
    logic        exp_mis;
`ifdef ELBETH_PC_ALIGN_CHECK_EN
    exp_pc   = 32'h100;
    exp_next = 32'h104;
    exp_mis  = 1'b1;
`else
    exp_pc   = 32'h102;
    exp_next = 32'h106;
    exp_mis  = 1'b0;
`endif
    jump(32'h102);
    checks++;
    if (pc !== exp_pc || misaligned !== exp_mis) begin
      failures++;
      $display("FAIL align pc=%h mis=%b exp %h/%b",
               pc, misaligned, exp_pc, exp_mis);
    end
    tick();
    checks++;
    if (pc !== exp_next || misaligned !== 1'b0) begin
      failures++;
      $display("FAIL align_next pc=%h mis=%b exp %h/0",
               pc, misaligned, exp_next);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_coincident();
    test_stalled_redirect();
    test_exc_over_branch();
    test_branch_overwrite();
    test_wrap();
    test_reset_mid_hold();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elbeth_pc_unit.md
ELBETH_PC_UNIT -- requirements
Module: elbeth_pc_unit

Interface
REQ-001 Parameter XLEN, default 32, PC and target width in bits (legal range 16..64).
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000 (XLEN bits), PC value loaded by reset.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 ctrl_stall  input  1  1 = PC SHALL hold.
REQ-006 branch_taken  input  1  redirect request from branch/jump unit.
REQ-007 branch_target  input  XLEN  branch redirect address.
REQ-008 exc_req  input  1  redirect request from exception/trap unit.
REQ-009 exc_target  input  XLEN  exception redirect address.
REQ-010 pc  output  XLEN  registered current fetch address.
REQ-011 pc_seq  output  XLEN  combinational pc + 4, modulo 2^XLEN.
REQ-012 pc_valid  output  1  registered, 1 = pc is a fetchable address.
REQ-013 misaligned  output  1  registered, 1-cycle pulse on misaligned applied redirect (see Configuration).

Function
REQ-014 The block SHALL implement states BOOT, RUN, HOLD.
REQ-015 BOOT: pc SHALL equal RESET_VECTOR, pc_valid 0; next edge SHALL enter RUN with pc unchanged, regardless of ctrl_stall or redirect inputs.
REQ-016 RUN, ctrl_stall=0: pc SHALL load exc_target if exc_req, else branch_target if branch_taken, else pc + 4.
REQ-017 Priority SHALL be exc_req > branch_taken > sequential when requests coincide.
REQ-018 RUN, ctrl_stall=1, no request: pc SHALL hold, state stays RUN.
REQ-019 RUN, ctrl_stall=1, request present: pc SHALL hold; winning target and its source (exc/branch) SHALL be captured in a pending register; state SHALL enter HOLD.
REQ-020 HOLD, ctrl_stall=1: pc SHALL hold; exc_req SHALL overwrite pending (source=exc); branch_taken SHALL overwrite pending only if pending source is branch; otherwise ignored.
REQ-021 HOLD, ctrl_stall=0: pc SHALL load exc_target if exc_req, else branch_target if branch_taken and pending source is branch, else pending target; state SHALL enter RUN; pending source SHALL clear.
REQ-022 Latency: redirect applied in an unstalled cycle SHALL appear on pc one edge later; a redirect is never lost by a stall.
REQ-023 pc + 4 SHALL wrap modulo 2^XLEN (all-ones minus 3 -> 0).
REQ-024 pc_valid SHALL be 1 in RUN and HOLD.

Reset
REQ-025 rst=0 SHALL asynchronously force pc=RESET_VECTOR, state=BOOT, pc_valid=0, misaligned=0, pending target=0, pending source=none.
REQ-026 Reset asserted mid-HOLD SHALL discard the pending redirect; first fetch after release SHALL be RESET_VECTOR.
REQ-027 Reset release SHALL take effect on the first rising clk edge with rst=1.

Configuration
REQ-028 Macro ELBETH_PC_ALIGN_CHECK_EN defined: an applied redirect target with bits [1:0] != 0 SHALL load pc with bits [1:0] cleared and pulse misaligned=1 for the one cycle in which the new pc is presented.
REQ-029 Macro undefined: targets SHALL load unmodified and misaligned SHALL be constant 0.

Verification
REQ-030 Reset/boot: rst=0 then release, no requests -> pc=0, pc_valid 0 for one cycle, then 0x0,0x4,0x8 with pc_valid=1.
REQ-031 Coincident redirect: RUN at pc=0x100, exc_req with exc_target=0x200 and branch_taken with branch_target=0x300 in the same cycle -> next pc=0x200.
REQ-032 Stalled redirect: pc=0x40, ctrl_stall=1 and branch_taken with branch_target=0x80 for one cycle, stall held 3 more cycles -> pc=0x40 throughout, 0x80 on the edge after stall drops, then 0x84.
REQ-033 Exception over pending branch: in HOLD with pending branch 0x80, exc_req with exc_target=0x1C0 while stalled -> pc=0x1C0 after stall release; later branch during same HOLD ignored.
REQ-034 Wrap and reset mid-HOLD: XLEN=32, pc=0xFFFF_FFFC unstalled -> pc=0x0; separately, rst=0 during HOLD -> pc=RESET_VECTOR, pending discarded.
REQ-035 Alignment (macro defined): branch_target=0x102 -> pc=0x100 with misaligned=1 for one cycle; macro undefined -> pc=0x102, misaligned=0.
